// File: rtl/truth_table_sweeper_if.sv
// Control and result bundle between the sweeper and the block/board harness it exercises.
// Master is the sweeper side: it drives X and the results, and samples start and F.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic [N_IN-1:0]        X;
    logic                   F;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic [N_IN-1:0]        first_fail;
    logic                   fail_valid;
    logic [(1<<N_IN)-1:0]   cap;

    modport master (
        input  start, F,
        output X, busy, done, pass, err_count, first_fail, fail_valid, cap
    );

    modport slave (
        output start, F,
        input  X, busy, done, pass, err_count, first_fail, fail_valid, cap
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps X through every vector, samples F after SETTLE stable cycles, scores against EXPECTED.
// Latency 2**N_IN*(SETTLE+1) cycles from start to done; no backpressure, start ignored while busy.
module truth_table_sweeper #(
    parameter int                   N_IN     = 3,
    parameter int                   SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'b1110_1000
) (
    input  logic               clk,
    input  logic               rst,
    truth_table_sweeper_if.master bus
);
    localparam int              NVEC    = 1 << N_IN;
    localparam int              CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST    = N_IN'(NVEC - 1);
    localparam logic [CW-1:0]   CNT_END = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t            state;
    state_t            stateNext;
    logic [CW-1:0]     cnt;
    logic [N_IN-1:0]   xReg;
    logic              busyReg;
    logic              doneReg;
    logic              passReg;
    logic [N_IN:0]     errCount;
    logic [N_IN:0]     errNext;
    logic [N_IN-1:0]   firstFail;
    logic              failValid;
    logic [NVEC-1:0]   capReg;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        mismatch  = (bus.F != EXPECTED[xReg]);
        errNext   = errCount + {{N_IN{1'b0}}, mismatch};
        case (state)
            IDLE:    if (bus.start) stateNext = WAIT;
            WAIT:    if (cnt == CNT_END) stateNext = SAMPLE;
            SAMPLE:  stateNext = (xReg == LAST) ? DONE : WAIT;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // pass is resolved on the last sample so it is already valid while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            xReg      <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            passReg   <= 1'b0;
            errCount  <= '0;
            firstFail <= '0;
            failValid <= 1'b0;
            capReg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt       <= '0;
                        xReg      <= '0;
                        busyReg   <= 1'b1;
                        passReg   <= 1'b0;
                        errCount  <= '0;
                        firstFail <= '0;
                        failValid <= 1'b0;
                        capReg    <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                end
                SAMPLE: begin
                    capReg[xReg] <= bus.F;
                    if (mismatch) begin
                        errCount <= errNext;
                        if (!failValid) begin
                            firstFail <= xReg;
                            failValid <= 1'b1;
                        end
                    end
                    if (xReg == LAST) begin
                        doneReg <= 1'b1;
                        passReg <= (errNext == '0);
                    end else begin
                        xReg <= xReg + 1'b1;
                        cnt  <= '0;
                    end
                end
                DONE: begin
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.X          = xReg;
    assign bus.busy       = busyReg;
    assign bus.done       = doneReg;
    assign bus.pass       = passReg;
    assign bus.err_count  = errCount;
    assign bus.first_fail = firstFail;
    assign bus.fail_valid = failValid;
    assign bus.cap        = capReg;
endmodule
